alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle 64-bit unsigned multiplier that computes a product by driving the shared combinational ALU as its adder, using shift-and-add with early termination. It is the initiating side of the ALU interface: it sources `a`, `b` and the 4-bit ALU control code, and consumes `result` and `zero`. It sits beside the datapath ALU and is used for MUL-class instructions. Its outputs are muxed onto the ALU inputs while `busy` is high.

## Interface
Parameters: none. Widths are fixed at 64-bit data and 4-bit ALU control.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `multiplicand`  in  64  operand A; captured on accepted `start`.
- `multiplier`  in  64  operand B; captured on accepted `start`.
- `busy`  out  1  high in CHECK and STEP.
- `done`  out  1  one-cycle pulse; high in DONE.
- `product`  out  64  low 64 bits of A×B; valid while `done` is high, held until the next accepted `start`.
- `alu_a`  out  64  ALU operand a.
- `alu_b`  out  64  ALU operand b.
- `alu_ctrl`  out  4  ALU control code: 0000 AND, 0010 ADD, 0111 pass-b.
- `alu_result`  in  64  ALU result (combinational, same cycle).
- `alu_zero`  in  1  ALU zero flag (combinational, same cycle).

## Operation
Registers:
- `mcand` (64): multiplicand.
- `mplier` (64): multiplier.
- `acc` (64): accumulator; drives `product`.
- `state`: IDLE, CHECK, STEP, DONE.

States:
- **IDLE**
  - ALU outputs: `alu_a`=0, `alu_b`=0, `alu_ctrl`=0000.
  - On `start`: `mcand`<=multiplicand, `mplier`<=multiplier, `acc`<=0, go to CHECK.
- **CHECK**
  - ALU outputs: `alu_b`=`mplier`, `alu_a`=0, `alu_ctrl`=0111 (pass-b).
  - If `alu_zero`, go to DONE; otherwise go to STEP.
- **STEP**
  - ALU outputs: `alu_a`=`acc`, `alu_b` = `mplier[0]` ? `mcand` : 0, `alu_ctrl`=0010 (ADD).
  - Register updates: `acc`<=`alu_result`, `mcand`<=`mcand`<<1, `mplier`<=`mplier`>>1 (logical).
  - Next state: CHECK.
- **DONE**
  - `done`=1; ALU outputs as in IDLE.
  - On `start`: capture new operands as in IDLE and go to CHECK (back-to-back operation).
  - Otherwise go to IDLE.

Rules and boundary conditions:
- All arithmetic is modulo 2^64; overflow silently wraps and is not flagged.
- The termination decision uses only the ALU `alu_zero` flag, never a local compare.
- `start` in CHECK or STEP is ignored. Operands and sequencing are unaffected.
- Reset mid-operation returns the block to IDLE immediately. The in-flight result is discarded; no `done` pulse is produced.

## Timing
- Reset values: state=IDLE, `acc`=`mcand`=`mplier`=0, `busy`=0, `done`=0, `product`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=0000.
- Let k = index of the highest set bit of `multiplier`.
- `done` is high in cycle 2(k+1)+2 after the accepting edge, counting the first CHECK cycle as cycle 1.
- `multiplier`=0 gives `done` in cycle 2. The worst case, k=63, gives cycle 130.
- `busy` is high for exactly cycles 1 .. 2(k+1)+1. It is never high together with `done`.
- `product` updates only on STEP edges. It is stable from the final CHECK cycle onward.
- The ALU is combinational, so every STEP consumes `alu_result` in the same cycle it is issued.

## Test plan
- **Basic multiply:** multiplicand=3, multiplier=5, `start` pulse -> `alu_ctrl` sequence 0111,0010,0111,0010,0111,0010,0111; `done` in cycle 8; `product`=15.
- **Zero multiplier:** multiplier=0, multiplicand=0x1234 -> CHECK once; `done` in cycle 2; `product`=0; STEP never entered.
- **Wrap-around:** multiplicand=0xFFFF_FFFF_FFFF_FFFF, multiplier=2 -> `product`=0xFFFF_FFFF_FFFF_FFFE; `done` in cycle 6.
- **Worst-case latency:** multiplicand=1, multiplier=0x8000_0000_0000_0000 -> `done` in cycle 130; `product`=0x8000_0000_0000_0000; `busy` high for cycles 1-129.
- **Ignored start:** 7×9 in flight; `start` with operands 2,2 in cycle 3 -> result still 63 with unchanged latency. Then `start` (4×4) in the DONE cycle -> next `done` 8 cycles later with `product`=16.
- **Reset mid-operation:** deassert `reset_n` during STEP of 0xFF×0xFF -> all outputs reset values asynchronously. After release, a new 6×7 run yields 42.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle 64-bit unsigned shift-and-add multiplier. It uses the shared
// combinational datapath ALU as its adder. It first asks the ALU to pass the
// remaining multiplier through, so the ALU zero flag shows whether any
// multiplier bits are left. When none are left, the operation ends early.
// Each STEP adds the shifted multiplicand, or zero, into the accumulator
// through the ALU. After that the multiplicand shifts left and the multiplier
// shifts right.

module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [63:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] CTRL_AND    = 4'b0000;
  localparam logic [3:0] CTRL_ADD    = 4'b0010;
  localparam logic [3:0] CTRL_PASS_B = 4'b0111;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [63:0] r_acc;
  logic        w_accept;

  // A new request is taken only while no operation is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Next-state selection. Termination relies solely on the ALU zero flag.
  always_comb begin
    // NOTE: assign a default first so that every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_accept ? S_CHECK : S_IDLE;
      S_CHECK: w_next_state = alu_zero ? S_DONE : S_STEP;
      S_STEP:  w_next_state = S_CHECK;
      S_DONE:  w_next_state = w_accept ? S_CHECK : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight at once.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Operand capture on an accepted start, and shift-and-add on each STEP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_mcand  <= multiplicand;
      r_mplier <= multiplier;
      r_acc    <= '0;
    end else if (r_state == S_STEP) begin
      r_acc    <= alu_result;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // ALU operand and control drive, selected by state.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = CTRL_AND;
    case (r_state)
      S_CHECK: begin
        alu_b    = r_mplier;
        alu_ctrl = CTRL_PASS_B;
      end
      S_STEP: begin
        alu_a    = r_acc;
        alu_b    = r_mplier[0] ? r_mcand : '0;
        alu_ctrl = CTRL_ADD;
      end
      default: ;
    endcase
  end

  assign busy    = (r_state == S_CHECK) || (r_state == S_STEP);
  assign done    = (r_state == S_DONE);
  assign product = r_acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer. A behavioural ALU is attached to the
// sequencer. Expected products and latencies are queued when each operation
// is issued. They are popped and compared when done appears.

module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_zero;

  alu_mul_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU: AND, ADD, pass-b.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0111: alu_result = alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          obs_lat;
  int          obs_busy;
  bit          obs_overlap;
  logic [63:0] obs_prod;
  logic [3:0]  ctrl_log [0:255];

  // Model: the product modulo 2^64, and the done cycle 2(k+1)+2 (which is 2 for a zero multiplier).
  task automatic push_expected(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int   k;
    e.prod = a * b;
    k = -1;
    for (int i = 0; i < 64; i++) if (b[i]) k = i;
    e.lat = 2 * (k + 1) + 2;
    sb.push_back(e);
  endtask

  // Drives start in the current cycle. The next rising edge accepts it.
  task automatic issue_now(input logic [63:0] a, input logic [63:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    push_expected(a, b);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    issue_now(a, b);
  endtask

  // Counts cycles after the accepting edge and samples on falling edges. The wait is bounded.
  task automatic wait_done;
    bit found;
    found       = 1'b0;
    obs_lat     = -1;
    obs_busy    = 0;
    obs_overlap = 1'b0;
    obs_prod    = 'x;
    for (int c = 1; c <= 200 && !found; c++) begin
      @(negedge clk);
      ctrl_log[c] = alu_ctrl;
      if (busy) obs_busy++;
      if (busy && done) obs_overlap = 1'b1;
      if (done) begin
        found    = 1'b1;
        obs_lat  = c;
        obs_prod = product;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, product, alu_a, alu_b, alu_ctrl} !== {2'b00, 64'd0, 64'd0, 64'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_during: busy=%b done=%b product=%h a=%h b=%h ctrl=%b, expected all zero",
               busy, done, product, alu_a, alu_b, alu_ctrl);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, product, alu_ctrl} !== {2'b00, 64'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_after: busy=%b done=%b product=%h ctrl=%b, expected all zero",
               busy, done, product, alu_ctrl);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    issue(64'd3, 64'd5);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_lat !== e.lat) begin
      failures++; $display("FAIL basic_latency: got %0d, expected %0d", obs_lat, e.lat);
    end
    checks++;
    if (obs_prod !== e.prod) begin
      failures++; $display("FAIL basic_product: got %0d, expected %0d", obs_prod, e.prod);
    end
    checks++;
    if (obs_busy !== e.lat - 1 || obs_overlap) begin
      failures++; $display("FAIL basic_busy: busy cycles %0d overlap %b, expected %0d and 0", obs_busy, obs_overlap, e.lat - 1);
    end
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (ctrl_log[c] !== ((c % 2 == 1) ? 4'b0111 : 4'b0010)) begin
        failures++; $display("FAIL basic_ctrl_cycle%0d: got %b, expected %b", c, ctrl_log[c], (c % 2 == 1) ? 4'b0111 : 4'b0010);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || product !== 64'd15) begin
      failures++; $display("FAIL basic_hold: done=%b product=%0d, expected 0 and 15", done, product);
    end
  endtask

  task automatic test_zero;
    exp_t e;
    issue(64'h1234, 64'd0);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_lat !== 2 || obs_lat !== e.lat) begin
      failures++; $display("FAIL zero_latency: got %0d, expected 2", obs_lat);
    end
    checks++;
    if (obs_prod !== e.prod || obs_busy !== 1 || ctrl_log[1] !== 4'b0111) begin
      failures++; $display("FAIL zero_flow: product=%h busy=%0d ctrl1=%b, expected 0, 1, 0111", obs_prod, obs_busy, ctrl_log[1]);
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_prod !== 64'hFFFF_FFFF_FFFF_FFFE || obs_prod !== e.prod) begin
      failures++; $display("FAIL wrap_product: got %h, expected fffffffffffffffe", obs_prod);
    end
    checks++;
    if (obs_lat !== 6) begin
      failures++; $display("FAIL wrap_latency: got %0d, expected 6", obs_lat);
    end
  endtask

  task automatic test_worst;
    exp_t e;
    issue(64'd1, 64'h8000_0000_0000_0000);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_lat !== 130 || obs_lat !== e.lat) begin
      failures++; $display("FAIL worst_latency: got %0d, expected 130", obs_lat);
    end
    checks++;
    if (obs_prod !== e.prod) begin
      failures++; $display("FAIL worst_product: got %h, expected %h", obs_prod, e.prod);
    end
    checks++;
    if (obs_busy !== 129 || obs_overlap) begin
      failures++; $display("FAIL worst_busy: busy cycles %0d overlap %b, expected 129 and 0", obs_busy, obs_overlap);
    end
  endtask

  // A start arriving mid-operation is ignored. A start during DONE chains the next operation.
  task automatic test_ignored_and_back_to_back;
    exp_t e;
    issue(64'd7, 64'd9);
    fork
      wait_done();
      begin
        repeat (3) @(negedge clk);
        multiplicand = 64'd2;
        multiplier   = 64'd2;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    e = sb.pop_front();
    checks++;
    if (obs_prod !== 64'd63 || obs_prod !== e.prod || obs_lat !== e.lat) begin
      failures++; $display("FAIL ignored_start: product=%0d lat=%0d, expected %0d lat %0d", obs_prod, obs_lat, e.prod, e.lat);
    end
    issue_now(64'd4, 64'd4);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_lat !== 8 || obs_lat !== e.lat) begin
      failures++; $display("FAIL b2b_latency: got %0d, expected 8", obs_lat);
    end
    checks++;
    if (obs_prod !== 64'd16) begin
      failures++; $display("FAIL b2b_product: got %0d, expected 16", obs_prod);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    issue(64'hFF, 64'hFF);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_ctrl !== 4'b0010 || product !== 64'hFF) begin
      failures++; $display("FAIL midreset_pre: busy=%b ctrl=%b product=%h, expected 1, 0010, ff", busy, alu_ctrl, product);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, product, alu_a, alu_b, alu_ctrl} !== {2'b00, 64'd0, 64'd0, 64'd0, 4'd0}) begin
      failures++;
      $display("FAIL midreset_async: busy=%b done=%b product=%h a=%h b=%h ctrl=%b, expected all zero",
               busy, done, product, alu_a, alu_b, alu_ctrl);
    end
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_nodone: done=%b busy=%b, expected 0 0", done, busy);
    end
    issue(64'd6, 64'd7);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (obs_prod !== 64'd42 || obs_lat !== e.lat) begin
      failures++; $display("FAIL midreset_rerun: product=%0d lat=%0d, expected 42 lat %0d", obs_prod, obs_lat, e.lat);
    end
  endtask

  task automatic test_random;
    exp_t        e;
    logic [63:0] a;
    logic [63:0] b;
    for (int n = 0; n < 4; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      issue(a, b);
      wait_done();
      e = sb.pop_front();
      checks++;
      if (obs_prod !== e.prod || obs_lat !== e.lat) begin
        failures++; $display("FAIL random_%0d: product=%h lat=%0d, expected %h lat %0d", n, obs_prod, obs_lat, e.prod, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_worst();
    test_ignored_and_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
